// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for the single-ported data RAM.
// Port 0 is the pipeline MEM stage, which is stalled while its access is in flight.
// Port 1 is the loader/debug port.
// Each access passes through IDLE -> [WAIT x WAIT_CYCLES] -> ACC -> RESP.
// Build option DMEM_ARB_RR_EN: round-robin arbitration when both ports are eligible.
// When the macro is not defined, port 0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req0,
  input  logic              We0,
  input  logic [31:0]       Addr0,
  input  logic [31:0]       WData0,
  output logic [31:0]       RData0,
  output logic              Done0,
  output logic              Stall0,
  input  logic              Req1,
  input  logic              We1,
  input  logic [31:0]       Addr1,
  input  logic [31:0]       WData1,
  output logic [31:0]       RData1,
  output logic              Done1,
  output logic              RamEn,
  output logic              RamWE,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [31:0]       RamWData,
  input  logic [31:0]       RamRData
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACC, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata0_q, rdata0_d;
  logic [31:0]        rdata1_q, rdata1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               ram_en_q, ram_en_d;
  logic               ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [31:0]        ram_wdata_q, ram_wdata_d;
  logic               elig0, elig1, grant_id;
`ifdef DMEM_ARB_RR_EN
  logic               last_q, last_d;
`endif

  // Byte offset and address bits above the RAM size are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Addr0[31:ADDR_W+2], Addr0[1:0], Addr1[31:ADDR_W+2], Addr1[1:0]};

  // Next-state, latch and response logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    // A port in its Done cycle is masked so a held Req is not re-granted at once.
    elig0    = Req0 & ~done0_q;
    elig1    = Req1 & ~done1_q;
`ifdef DMEM_ARB_RR_EN
    last_d   = last_q;
    grant_id = (elig0 & elig1) ? ~last_q : elig1;
`else
    grant_id = ~elig0;
`endif
    unique case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          gnt_d   = grant_id;
          we_d    = grant_id ? We1 : We0;
          addr_d  = grant_id ? Addr1[ADDR_W+1:2] : Addr0[ADDR_W+1:2];
          wdata_d = grant_id ? WData1 : WData0;
`ifdef DMEM_ARB_RR_EN
          last_d  = grant_id;
`endif
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = ACC;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACC;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACC: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (gnt_q) begin
          done1_d = 1'b1;
          if (!we_q) rdata1_d = RamRData;
        end else begin
          done0_d = 1'b1;
          if (!we_q) rdata0_d = RamRData;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // RAM strobes are registered from the next state so they line up with ACC.
    ram_en_d    = (state_d == ACC);
    ram_we_d    = ram_en_d & we_d;
    ram_addr_d  = ram_en_d ? addr_d : '0;
    ram_wdata_d = ram_en_d ? wdata_d : '0;
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer: remembers the last granted port (reset favours port 0 next).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif

  assign RData0   = rdata0_q;
  assign RData1   = rdata1_q;
  assign Done0    = done0_q;
  assign Done1    = done1_q;
  assign Stall0   = Req0 & ~done0_q;
  assign RamEn    = ram_en_q;
  assign RamWE    = ram_we_q;
  assign RamAddr  = ram_addr_q;
  assign RamWData = ram_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter.
// Instance a uses WAIT_CYCLES=2; instance b uses WAIT_CYCLES=0 and drives port 1 only.
module tb_dmem_arbiter;

  localparam int unsigned AW = 9;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          a_req0, a_we0, a_done0, a_stall0, a_req1, a_we1, a_done1;
  logic [31:0]   a_addr0, a_wdata0, a_rdata0, a_addr1, a_wdata1, a_rdata1;
  logic          a_ram_en, a_ram_we;
  logic [AW-1:0] a_ram_addr;
  logic [31:0]   a_ram_wdata, a_ram_rdata;

  logic          b_req0, b_we0, b_done0, b_stall0, b_req1, b_we1, b_done1;
  logic [31:0]   b_addr0, b_wdata0, b_rdata0, b_addr1, b_wdata1, b_rdata1;
  logic          b_ram_en, b_ram_we;
  logic [AW-1:0] b_ram_addr;
  logic [31:0]   b_ram_wdata, b_ram_rdata;

  logic [31:0] mem_a [512];
  logic [31:0] mem_b [512];

  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut_a (
    .CLK(CLK), .RST(RST),
    .Req0(a_req0), .We0(a_we0), .Addr0(a_addr0), .WData0(a_wdata0),
    .RData0(a_rdata0), .Done0(a_done0), .Stall0(a_stall0),
    .Req1(a_req1), .We1(a_we1), .Addr1(a_addr1), .WData1(a_wdata1),
    .RData1(a_rdata1), .Done1(a_done1),
    .RamEn(a_ram_en), .RamWE(a_ram_we), .RamAddr(a_ram_addr),
    .RamWData(a_ram_wdata), .RamRData(a_ram_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut_b (
    .CLK(CLK), .RST(RST),
    .Req0(b_req0), .We0(b_we0), .Addr0(b_addr0), .WData0(b_wdata0),
    .RData0(b_rdata0), .Done0(b_done0), .Stall0(b_stall0),
    .Req1(b_req1), .We1(b_we1), .Addr1(b_addr1), .WData1(b_wdata1),
    .RData1(b_rdata1), .Done1(b_done1),
    .RamEn(b_ram_en), .RamWE(b_ram_we), .RamAddr(b_ram_addr),
    .RamWData(b_ram_wdata), .RamRData(b_ram_rdata)
  );

  // Synchronous RAM models: read data valid the cycle after the strobe.
  always @(posedge CLK) begin
    if (a_ram_en) begin
      if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
      a_ram_rdata <= mem_a[a_ram_addr];
    end
    if (b_ram_en) begin
      if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
      b_ram_rdata <= mem_b[b_ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_a(input int port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      a_req0 = req; a_we0 = we; a_addr0 = addr; a_wdata0 = wdata;
    end else begin
      a_req1 = req; a_we1 = we; a_addr1 = addr; a_wdata1 = wdata;
    end
  endtask

  // One uncontested access on instance a (W=2), checked cycle by cycle c0..c5.
  task automatic acc_a(input string name, input int port, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rd_exp, input logic [31:0] other_exp);
    logic [AW-1:0] waddr;
    waddr = addr[AW+1:2];
    for (int k = 0; k <= 5; k++) begin
      cyc();
      if (k == 0) drive_a(port, 1'b1, we, addr, wdata);
      #1;
      check($sformatf("%s c%0d RamEn", name, k), 32'(a_ram_en), 32'(k == 3));
      check($sformatf("%s c%0d RamWE", name, k), 32'(a_ram_we), 32'((k == 3) && we));
      check($sformatf("%s c%0d RamAddr", name, k), 32'(a_ram_addr), (k == 3) ? 32'(waddr) : 32'd0);
      check($sformatf("%s c%0d RamWData", name, k), a_ram_wdata, (k == 3) ? wdata : 32'd0);
      check($sformatf("%s c%0d Done0", name, k), 32'(a_done0), 32'((k == 5) && (port == 0)));
      check($sformatf("%s c%0d Done1", name, k), 32'(a_done1), 32'((k == 5) && (port == 1)));
      check($sformatf("%s c%0d Stall0", name, k), 32'(a_stall0), 32'((k < 5) && (port == 0)));
    end
    check($sformatf("%s RData%0d", name, port), (port == 0) ? a_rdata0 : a_rdata1, rd_exp);
    check($sformatf("%s RData%0d other", name, 1 - port), (port == 0) ? a_rdata1 : a_rdata0, other_exp);
    cyc();
    drive_a(port, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // One port-1 read on instance b (W=0): strobe in c1, Done in c3.
  task automatic acc_b(input string name, input logic [31:0] addr, input logic [31:0] rd_exp);
    for (int k = 0; k <= 3; k++) begin
      cyc();
      if (k == 0) begin
        b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = addr;
      end
      #1;
      check($sformatf("%s c%0d RamEn", name, k), 32'(b_ram_en), 32'(k == 1));
      check($sformatf("%s c%0d Done1", name, k), 32'(b_done1), 32'(k == 3));
    end
    check($sformatf("%s RData1", name), b_rdata1, rd_exp);
    cyc();
    b_req1 = 1'b0;
  endtask

  initial begin
    int first;
    int d0k;
    int d1k;
    int n_we;
    int n_done;
    logic req0_now;

    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'hA500_0000 | 32'(i);
    end
    a_ram_rdata = 32'd0;
    b_ram_rdata = 32'd0;
    RST = 1'b1;
    drive_a(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_a(1, 1'b0, 1'b0, 32'd0, 32'd0);
    b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = 32'd0; b_wdata0 = 32'd0;
    b_req1 = 1'b0; b_we1 = 1'b0; b_addr1 = 32'd0; b_wdata1 = 32'd0;

    cyc();
    cyc();
    check("reset RamEn", 32'(a_ram_en), 32'd0);
    check("reset Done0", 32'(a_done0), 32'd0);
    check("reset Done1", 32'(a_done1), 32'd0);
    check("reset RData0", a_rdata0, 32'd0);
    check("reset Stall0", 32'(a_stall0), 32'd0);
    RST = 1'b0;

    acc_a("wr", 0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 32'd0);
    check("wr mem[4]", mem_a[4], 32'hDEAD_BEEF);
    acc_a("rd", 0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 32'd0);

    // Contention: port 0 reads 0x10, port 1 writes 0x20, raised together.
`ifdef DMEM_ARB_RR_EN
    first = 1;
`else
    first = 0;
`endif
    d0k = (first == 0) ? 5 : 10;
    d1k = (first == 1) ? 5 : 10;
    req0_now = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      cyc();
      if (k == 0) begin
        drive_a(0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive_a(1, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        req0_now = 1'b1;
      end
      if (k == 6) begin
        drive_a(first, 1'b0, 1'b0, 32'd0, 32'd0);
        if (first == 0) req0_now = 1'b0;
      end
      if (k == 11) begin
        drive_a(1 - first, 1'b0, 1'b0, 32'd0, 32'd0);
        if (first == 1) req0_now = 1'b0;
      end
      #1;
      check($sformatf("cont c%0d RamEn", k), 32'(a_ram_en), 32'((k == 3) || (k == 8)));
      check($sformatf("cont c%0d RamWE", k), 32'(a_ram_we),
            32'(((k == 3) && (first == 1)) || ((k == 8) && (first == 0))));
      check($sformatf("cont c%0d Done0", k), 32'(a_done0), 32'(k == d0k));
      check($sformatf("cont c%0d Done1", k), 32'(a_done1), 32'(k == d1k));
      check($sformatf("cont c%0d Stall0", k), 32'(a_stall0), 32'(req0_now && (k != d0k)));
      if (k == d0k) check("cont RData0", a_rdata0, 32'hDEAD_BEEF);
    end
    check("cont mem[8]", mem_a[8], 32'h1234_5678);

    // Reset in the middle of a port-1 write.
    cyc();
    drive_a(1, 1'b1, 1'b1, 32'h8, 32'hCAFE_F00D);
    cyc();
    RST = 1'b1;
    #1;
    check("rst RamEn", 32'(a_ram_en), 32'd0);
    check("rst RamWE", 32'(a_ram_we), 32'd0);
    check("rst RamAddr", 32'(a_ram_addr), 32'd0);
    check("rst RamWData", a_ram_wdata, 32'd0);
    check("rst Done1", 32'(a_done1), 32'd0);
    check("rst RData0", a_rdata0, 32'd0);
    check("rst RData1", a_rdata1, 32'd0);
    check("rst Stall0", 32'(a_stall0), 32'd0);
    drive_a(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    RST = 1'b0;
    n_we = 0;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (a_ram_we) n_we++;
      if (a_done1) n_done++;
    end
    check("rst no RamWE", 32'(n_we), 32'd0);
    check("rst no Done1", 32'(n_done), 32'd0);
    check("rst mem[2]", mem_a[2], 32'd0);
    acc_a("post wr", 1, 1'b1, 32'h8, 32'hCAFE_F00D, 32'd0, 32'd0);
    acc_a("post rd", 0, 1'b0, 32'h8, 32'd0, 32'hCAFE_F00D, 32'd0);

    // Zero wait states, back-to-back reads on port 1.
    acc_b("w0 a", 32'h40, 32'hA500_0010);
    acc_b("w0 b", 32'h44, 32'hA500_0011);
    check("w0 RData0", b_rdata0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-ported 512-word data RAM. It shares the RAM between the pipeline MEM stage (port 0) and a loader/debug port (port 1). Each access passes through a multi-cycle sequence with a programmable wait-state count. While a MEM-stage access is in flight, the block drives a stall to the pipeline.

## Interface
- ADDR_W, 9, RAM word-address width (512 words)
- WAIT_CYCLES, 2, extra wait states before the RAM strobe; legal range 0..15
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- Req0  in  1  port 0 request; held with fields stable until Done0
- We0  in  1  port 0 write (1) / read (0)
- Addr0  in  32  port 0 byte address
- WData0  in  32  port 0 write data
- RData0  out  32  port 0 read data, registered
- Done0  out  1  port 0 completion, one-cycle pulse
- Stall0  out  1  pipeline stall, = Req0 & ~Done0 (combinational)
- Req1, We1, Addr1, WData1  in  1/1/32/32  port 1, same rules as port 0
- RData1, Done1  out  32/1  port 1 response
- RamEn  out  1  RAM access strobe
- RamWE  out  1  RAM write enable (only with RamEn)
- RamAddr  out  ADDR_W  RAM word address
- RamWData  out  32  RAM write data
- RamRData  in  32  RAM read data, valid the cycle after RamEn

## Operation
- States: IDLE, WAIT, ACC, RESP. Reset state: IDLE.
- **IDLE**
  - A port is eligible when its Req is high and its Done is low (Done-cycle masking).
  - If any port is eligible, grant one and latch grant id, We, word address Addr[ADDR_W+1:2] and WData.
  - Address bits [1:0] and bits above ADDR_W+1 are ignored; there is no misalignment fault.
  - Next state: WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise ACC.
- **WAIT**
  - Counter (4 bits) decrements each cycle. At counter==0, go to ACC.
  - RAM outputs are idle.
- **ACC**
  - RamEn=1, RamWE=latched We; RamAddr/RamWData come from the latch.
  - Always goes to RESP.
- **RESP**
  - RamRData is valid in this cycle.
  - On the exiting edge:
    - For a read, RDataN <= RamRData. For a write, RDataN keeps its value.
    - DoneN <= 1 for exactly one cycle.
  - Next state: IDLE.
- Arbitration when both ports are eligible in IDLE: see Configuration.
- RamEn, RamWE, RamAddr and RamWData are 0 outside ACC.
- Only one access is in flight at a time; no pipelining.

## Timing
- Reset values: RData0=RData1=0, Done0=Done1=0, RamEn=RamWE=0, RamAddr=0, RamWData=0, state IDLE, RR pointer=1 (last granted = port 1).
- Stall0 follows Req0 and Done0 combinationally, so it is 0 whenever Req0=0.
- Latency, with Req sampled high in IDLE cycle c0 and W = WAIT_CYCLES:
  - WAIT occupies c1..cW.
  - ACC in c(W+1).
  - RESP in c(W+2).
  - Done plus valid RData in c(W+3).
  - Example, W=2: RamEn in c3, Done in c5.
- The Done cycle is an IDLE cycle.
  - The Done port is masked in that cycle; the other port may be granted in it.
  - The requester must drop Req in the cycle after Done. If Req is still high, it is a new request.
- Asynchronous RST mid-access:
  - Returns to IDLE immediately and forces RamEn/RamWE low.
  - The aborted access is dropped and not retried; no Done is issued.
- Request fields changing mid-access are ignored, since all fields are latched in IDLE.

## Configuration
- Macro DMEM_ARB_RR_EN selects the arbitration policy when both ports are eligible in the same IDLE cycle.
- **Defined: round-robin.**
  - Grant the port not granted last.
  - The pointer updates on every grant, including uncontested ones.
- **Undefined: fixed priority.**
  - Port 0 always wins.
  - The pointer logic is absent.

## Test plan
- **Reset:** assert RST mid-run.
  - All outputs 0 immediately; state IDLE.
- **Write, W=2:** Req0=1, We0=1, Addr0=0x10, WData0=0xDEADBEEF.
  - c3: RamEn=1, RamWE=1, RamAddr=4, RamWData=0xDEADBEEF.
  - c5: Done0=1.
  - Stall0=1 over c0..c4.
- **Readback, W=2:** Req0=1, We0=0, Addr0=0x10.
  - c3: RamEn=1, RamWE=0.
  - c5: Done0=1 and RData0=0xDEADBEEF.
  - RData1 stays 0.
- **Contention:** after one port-0-only access, raise Req0 and Req1 in the same IDLE cycle.
  - With DMEM_ARB_RR_EN: port 1 served first, port 0 granted in Done1's cycle.
  - Without it: port 0 first, port 1 granted in Done0's cycle.
- **Reset mid-access:** port 1 write to Addr1=0x8, RST pulsed during WAIT.
  - RamWE never asserts.
  - No Done1.
  - The next request completes normally.
- **WAIT_CYCLES=0:** Req1 read at c0.
  - c1: RamEn=1.
  - c3: Done1=1.
  - Back-to-back requests (Req dropped after Done, re-raised the next cycle) each complete in 3 cycles.
